axim_wr_packer: RTL and testbench

//  Store-side front end of the AXI master controller. Accepts one vector-store command, then a stream of SEW-wide elements with per-element mask bits.

---
 rtl/axim_wr_packer.sv | 231 +++++++++++++++++++++++
 tb/tb_axim_wr_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axim_wr_packer.sv
// axim_wr_packer: packs SEW-wide vector-store elements into bus words
// with byte strobes and drives the AXI master controller write path.
module axim_wr_packer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_NELEM_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_NELEM_WIDTH-1:0]          cmd_nelem,
    input  logic [1:0]                        cmd_sew,
    input  logic                              elem_valid,
    output logic                              elem_ready,
    input  logic [31:0]                       elem_data,
    input  logic                              elem_en,
    output logic                              ctrl_wstart,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_waddr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_wxfer_size,
    output logic                              ctrl_wstrb_msk_en,
    input  logic                              ctrl_wdone,
    output logic                              wr_tvalid,
    input  logic                              wr_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     wr_tdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   wr_tstrb_msk,
    output logic                              done
);

    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int XW  = C_XFER_SIZE_WIDTH;
    localparam int NW  = C_NELEM_WIDTH;
    localparam int DWB = DW / 8;
    localparam int LB  = $clog2(DWB);
    localparam int PW  = LB + 1;
    localparam int SW  = DWB + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PACK,
        S_WAIT,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XW-1:0]   size_q, size_d;
    logic [1:0]      sew_q, sew_d;
    logic [NW-1:0]   left_q, left_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DWB-1:0]  accs_q, accs_d;
    logic            tvalid_q, tvalid_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic [DWB-1:0]  tstrb_q, tstrb_d;

    logic [1:0]      sew_in;
    logic [LB-1:0]   off_in;
    logic [XW-1:0]   bytes_in;
    logic [XW-1:0]   size_in;
    logic [AW-1:0]   waddr_in;

    logic [PW-1:0]   esz;
    logic [PW-1:0]   ptr_nx;
    logic [31:0]     emask;
    logic [DW-1:0]   edata_ext;
    logic [DW-1:0]   edata_sh;
    logic [SW-1:0]   estrb_w;
    logic [DWB-1:0]  estrb_sh;
    logic [DW-1:0]   pack_acc;
    logic [DWB-1:0]  pack_strb;

    logic            cmd_fire;
    logic            elem_fire;
    logic            beat_fire;
    logic            last_beat;
    logic            emit;

    // Command arithmetic; SEW encoding 3 is folded onto 32-bit elements.
    assign sew_in   = (cmd_sew == 2'd3) ? 2'd2 : cmd_sew;
    assign off_in   = cmd_addr[LB-1:0];
    assign bytes_in = XW'(off_in) + (XW'(cmd_nelem) << sew_in);
    assign size_in  = (bytes_in + XW'(DWB - 1)) & ~XW'(DWB - 1);
    assign waddr_in = cmd_addr & ~AW'(DWB - 1);

    assign esz    = PW'(1) << sew_q;
    assign ptr_nx = ptr_q + esz;

    always_comb begin
        emask = 32'hFFFF_FFFF;
        unique case (1'b1)
            (sew_q == 2'd0): emask = 32'h0000_00FF;
            (sew_q == 2'd1): emask = 32'h0000_FFFF;
            default:         emask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        edata_ext        = '0;
        edata_ext[31:0]  = elem_data & emask;
    end

    assign edata_sh  = edata_ext << {ptr_q, 3'b000};
    assign estrb_w   = (SW'(1) << esz) - SW'(1);
    assign estrb_sh  = elem_en ? (estrb_w[DWB-1:0] << ptr_q) : '0;
    assign pack_acc  = acc_q | edata_sh;
    assign pack_strb = accs_q | estrb_sh;

    assign cmd_fire   = cmd_valid & ready_q;
    assign elem_ready = (state_q == S_PACK) && (left_q != '0) &&
                        (!tvalid_q || wr_tready);
    assign elem_fire  = elem_valid & elem_ready;
    assign beat_fire  = tvalid_q & wr_tready;
    // Once every element is packed, only the final word can be pending.
    assign last_beat  = beat_fire && (left_q == '0);
    assign emit       = elem_fire &&
                        ((ptr_nx == PW'(DWB)) || (left_q == NW'(1)));

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        size_d   = size_q;
        sew_d    = sew_q;
        left_d   = left_q;
        ptr_d    = ptr_q;
        acc_d    = acc_q;
        accs_d   = accs_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    waddr_d  = waddr_in;
                    size_d   = size_in;
                    sew_d    = sew_in;
                    left_d   = cmd_nelem;
                    ptr_d    = PW'(off_in);
                    acc_d    = '0;
                    accs_d   = '0;
                    tvalid_d = 1'b0;
                    state_d  = (cmd_nelem == '0) ? S_FIN : S_START;
                end
            end
            S_START: state_d = S_PACK;
            S_PACK: begin
                if (last_beat) begin
                    state_d = ctrl_wdone ? S_FIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ctrl_wdone) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (beat_fire) begin
            tvalid_d = 1'b0;
        end

        if (elem_fire) begin
            left_d = left_q - NW'(1);
            if (emit) begin
                tvalid_d = 1'b1;
                tdata_d  = pack_acc;
                tstrb_d  = pack_strb;
                acc_d    = '0;
                accs_d   = '0;
                ptr_d    = '0;
            end else begin
                acc_d    = pack_acc;
                accs_d   = pack_strb;
                ptr_d    = ptr_nx;
            end
        end
    end

    assign ready_d = (state_d == S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            waddr_q  <= '0;
            size_q   <= '0;
            sew_q    <= '0;
            left_q   <= '0;
            ptr_q    <= '0;
            acc_q    <= '0;
            accs_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            waddr_q  <= waddr_d;
            size_q   <= size_d;
            sew_q    <= sew_d;
            left_q   <= left_d;
            ptr_q    <= ptr_d;
            acc_q    <= acc_d;
            accs_q   <= accs_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
        end
    end

    assign cmd_ready         = ready_q;
    assign ctrl_wstart       = (state_q == S_START);
    assign ctrl_waddr_offset = waddr_q;
    assign ctrl_wxfer_size   = size_q;
    assign ctrl_wstrb_msk_en = (state_q == S_START) ||
                               (state_q == S_PACK)  ||
                               (state_q == S_WAIT);
    assign wr_tvalid         = tvalid_q;
    assign wr_tdata          = tdata_q;
    assign wr_tstrb_msk      = tstrb_q;
    assign done              = (state_q == S_FIN);

endmodule

// File: tb/tb_axim_wr_packer.sv
// Randomized bench for axim_wr_packer against a byte-array model of the
// packed transfer, with directed corner commands and a mid-burst reset.
module tb_axim_wr_packer;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int XW  = 32;
    localparam int NW  = 16;
    localparam int DWB = DW / 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr = '0;
    logic [NW-1:0]   cmd_nelem = '0;
    logic [1:0]      cmd_sew = '0;
    logic            elem_valid = 1'b0;
    logic            elem_ready;
    logic [31:0]     elem_data = '0;
    logic            elem_en = 1'b0;
    logic            ctrl_wstart;
    logic [AW-1:0]   ctrl_waddr_offset;
    logic [XW-1:0]   ctrl_wxfer_size;
    logic            ctrl_wstrb_msk_en;
    logic            ctrl_wdone = 1'b0;
    logic            wr_tvalid;
    logic            wr_tready = 1'b0;
    logic [DW-1:0]   wr_tdata;
    logic [DWB-1:0]  wr_tstrb_msk;
    logic            done;

    always #5 clk = ~clk;

    axim_wr_packer #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_XFER_SIZE_WIDTH  (XW),
        .C_NELEM_WIDTH      (NW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_nelem         (cmd_nelem),
        .cmd_sew           (cmd_sew),
        .elem_valid        (elem_valid),
        .elem_ready        (elem_ready),
        .elem_data         (elem_data),
        .elem_en           (elem_en),
        .ctrl_wstart       (ctrl_wstart),
        .ctrl_waddr_offset (ctrl_waddr_offset),
        .ctrl_wxfer_size   (ctrl_wxfer_size),
        .ctrl_wstrb_msk_en (ctrl_wstrb_msk_en),
        .ctrl_wdone        (ctrl_wdone),
        .wr_tvalid         (wr_tvalid),
        .wr_tready         (wr_tready),
        .wr_tdata          (wr_tdata),
        .wr_tstrb_msk      (wr_tstrb_msk),
        .done              (done)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]    el_d[$];
    bit             el_e[$];
    logic [DW-1:0]  ex_d[$];
    logic [DWB-1:0] ex_s[$];
    int             ex_size;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lay the elements out in a flat byte image of the transfer, then
    // slice it into bus words.
    function automatic void build(input logic [AW-1:0] addr, input int sew,
                                  input int n);
        int se;
        int esz;
        int off;
        int tot;
        logic [7:0] b[];
        bit s[];
        se  = (sew == 3) ? 2 : sew;
        esz = 1 << se;
        off = int'(addr % DWB);
        tot = off + n * esz;
        ex_size = ((tot + DWB - 1) / DWB) * DWB;
        b = new[ex_size];
        s = new[ex_size];
        foreach (b[k]) begin
            b[k] = 8'h00;
            s[k] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            logic [31:0] t;
            t = el_d[i];
            for (int j = 0; j < esz; j++) begin
                b[off + i * esz + j] = t[8*j +: 8];
                s[off + i * esz + j] = el_e[i];
            end
        end
        ex_d.delete();
        ex_s.delete();
        if (n > 0) begin
            for (int w = 0; w < ex_size / DWB; w++) begin
                logic [DW-1:0]  d;
                logic [DWB-1:0] st;
                for (int k = 0; k < DWB; k++) begin
                    d[8*k +: 8] = b[w * DWB + k];
                    st[k]       = s[w * DWB + k];
                end
                ex_d.push_back(d);
                ex_s.push_back(st);
            end
        end
    endfunction

    task automatic run(input logic [AW-1:0] addr, input int sew, input int n,
                       input int tr_pct, input int el_pct, input int wd_dly,
                       input int abort_at);
        int g;
        int idx;
        int nbeats;
        int nstart;
        int wd_cyc;
        int last_cyc;
        bit done_seen;
        bit first_rdy;
        bit stall_prev;
        logic [DW-1:0]  pd;
        logic [DWB-1:0] ps;
        build(addr, sew, n);
        idx = 0; nbeats = 0; nstart = 0; wd_cyc = -1; last_cyc = -1;
        done_seen = 0; first_rdy = 0; stall_prev = 0; pd = '0; ps = '0;
        @(negedge clk);
        elem_valid = 1'b0;
        ctrl_wdone = 1'b0;
        cmd_valid  = 1'b1;
        cmd_addr   = addr;
        cmd_sew    = sew[1:0];
        cmd_nelem  = n[NW-1:0];
        g = 0;
        while (!cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("cmd_ready", cmd_ready, 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int cyc = 1; cyc < 400 && !done_seen; cyc++) begin
            @(negedge clk);
            ctrl_wdone = 1'b0;
            if (last_cyc >= 0 && wd_cyc < 0 && cyc >= last_cyc + wd_dly) begin
                ctrl_wdone = 1'b1;
                wd_cyc = cyc;
            end
            wr_tready  = ($urandom_range(99) < tr_pct);
            elem_valid = ($urandom_range(99) < el_pct);
            elem_data  = (idx < n) ? el_d[idx] : $urandom;
            elem_en    = (idx < n) ? el_e[idx] : 1'($urandom);
            if (abort_at > 0 && idx == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("rst_ctrl", {cmd_ready, elem_ready, ctrl_wstart,
                    ctrl_wstrb_msk_en, wr_tvalid, done}, 0);
                chk("rst_addr", ctrl_waddr_offset, 0);
                chk("rst_size", ctrl_wxfer_size, 0);
                chk("rst_word", {wr_tdata, wr_tstrb_msk}, 0);
                @(negedge clk);
                rstn = 1'b1;
                elem_valid = 1'b0;
                wr_tready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    #1 chk("rst_no_done", done, 0);
                end
                return;
            end
            #1;
            if (cyc == 1) chk("busy_cmd_ready", cmd_ready, 0);
            if (ctrl_wstart) begin
                nstart++;
                chk("wstart_cyc", cyc, 1);
                chk("waddr", ctrl_waddr_offset, addr - (addr % DWB));
                chk("wsize", ctrl_wxfer_size, ex_size);
                chk("msk_en", ctrl_wstrb_msk_en, 1);
            end
            if (stall_prev) begin
                chk("hold_valid", wr_tvalid, 1);
                chk("hold_data", wr_tdata, pd);
                chk("hold_strb", wr_tstrb_msk, ps);
            end
            stall_prev = wr_tvalid && !wr_tready;
            pd = wr_tdata;
            ps = wr_tstrb_msk;
            if (elem_ready && !first_rdy) begin
                first_rdy = 1;
                chk("first_elem_ready", cyc, 2);
            end
            if (elem_valid && elem_ready) begin
                if (idx < n) idx++;
                else chk("extra_elem", 1, 0);
            end
            if (wr_tvalid && wr_tready) begin
                if (nbeats < ex_d.size()) begin
                    chk("beat_data", wr_tdata, ex_d[nbeats]);
                    chk("beat_strb", wr_tstrb_msk, ex_s[nbeats]);
                end else begin
                    chk("extra_beat", 1, 0);
                end
                nbeats++;
                if (nbeats == ex_d.size()) begin
                    last_cyc = cyc;
                    if (wd_dly == 0) begin
                        ctrl_wdone = 1'b1;
                        wd_cyc = cyc;
                    end
                end
            end
            if (done) begin
                done_seen = 1;
                if (n == 0) chk("done_lat_n0", cyc <= 2, 1);
                else        chk("done_cycle", cyc, wd_cyc + 1);
            end
        end
        ctrl_wdone = 1'b0;
        elem_valid = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("elems_taken", idx, n);
        chk("beat_count", nbeats, ex_d.size());
        chk("wstart_count", nstart, (n == 0) ? 0 : 1);
        @(negedge clk);
        #1;
        chk("done_width", done, 0);
        chk("idle_ready", cmd_ready, 1);
    endtask

    task automatic fill_rand(input int n, input int en_pct);
        el_d.delete();
        el_e.delete();
        for (int i = 0; i < n; i++) begin
            el_d.push_back($urandom);
            el_e.push_back($urandom_range(99) < en_pct);
        end
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1;
        chk("reset_ctrl", {cmd_ready, elem_ready, ctrl_wstart,
            ctrl_wstrb_msk_en, wr_tvalid, done}, 0);
        chk("reset_word", {ctrl_waddr_offset, wr_tdata}, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        el_d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        el_e = '{1, 1, 1, 1};
        run(32'h100, 2, 4, 100, 100, 3, 0);

        el_d = '{32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC};
        el_e = '{1, 1, 1};
        run(32'h103, 0, 3, 100, 100, 1, 0);

        el_d = '{32'hA1A1, 32'hB2B2, 32'hC3C3, 32'hD4D4};
        el_e = '{1, 0, 1, 1};
        run(32'h200, 1, 4, 100, 100, 0, 0);

        el_d = '{32'hDEAD_BEEF, 32'h1234_5678};
        el_e = '{0, 1};
        run(32'h300, 2, 2, 100, 100, 2, 0);

        el_d.delete();
        el_e.delete();
        run(32'h104, 0, 0, 100, 100, 0, 0);

        fill_rand(9, 80);
        run(32'h402, 1, 9, 50, 80, 20, 0);

        fill_rand(12, 100);
        run(32'h501, 0, 12, 100, 100, 0, 5);

        fill_rand(6, 100);
        run(32'h600, 0, 6, 100, 100, 1, 0);

        for (int t = 0; t < 30; t++) begin
            int sew;
            int se;
            int n;
            logic [AW-1:0] a;
            sew = $urandom_range(3);
            se  = (sew == 3) ? 2 : sew;
            n   = $urandom_range(20);
            a   = $urandom;
            a   = a & ~(32'((1 << se) - 1));
            fill_rand(n, 75);
            run(a, sew, n, 50, 70, $urandom_range(5), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
